// File: rtl/mips_defs.sv
// Shared MIPS definitions: MDU op encodings, default MDU latencies and HI/LO read select.
package mips_defs;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_NOP7  = 3'd7
  } mdu_op_e;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  // Ops that occupy the unit for several cycles and write both HI and LO.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: produces the 64-bit {hi,lo} result and a divide-by-zero flag.
module mdu_calc
  import mips_defs::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div0_o
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign a_zx   = {32'd0, a_i};
  assign b_zx   = {32'd0, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign a_mag      = a_i[31] ? -a_i : a_i;
  assign b_mag      = b_i[31] ? -b_i : b_i;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign q_s        = (a_i[31] ^ b_i[31]) ? -q_mag : q_mag;
  assign r_s        = a_i[31] ? -r_mag : r_mag;

  assign b_safe = (b_i == 32'd0) ? 32'd1 : b_i;
  assign q_u    = a_i / b_safe;
  assign r_u    = a_i % b_safe;

  always_comb begin
    res_o  = '0;
    div0_o = 1'b0;
    case (op_i)
      MDU_MULT:  res_o = prod_s;
      MDU_MULTU: res_o = prod_u;
      MDU_DIV: begin
        res_o  = {r_s, q_s};
        div0_o = (b_i == 32'd0);
      end
      MDU_DIVU: begin
        res_o  = {r_u, q_u};
        div0_o = (b_i == 32'd0);
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO: results are computed at accept, held pending,
// and committed on the edge where the busy counter expires.
module mdu_hilo
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        md_pend,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          commit_q, commit_d;
  logic [63:0]   calc_res;
  logic          calc_div0;

  mdu_calc u_calc (
    .op_i   (op),
    .a_i    (A),
    .b_i    (B),
    .res_o  (calc_res),
    .div0_o (calc_div0)
  );

  assign busy    = (cnt_q != '0);
  assign md_pend = start && is_md_op(op) && !busy;
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign RD      = (hilo_sel == HILO_SEL_HI) ? hi_q : lo_q;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    commit_d  = commit_q;
    if (busy) begin
      // Every start is dropped while running; HI/LO only change at expiry.
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && commit_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (md_pend) begin
      pend_hi_d = calc_res[63:32];
      pend_lo_d = calc_res[31:0];
      commit_d  = !calc_div0;
      cnt_d     = (op == MDU_MULT || op == MDU_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (start && op == MDU_MTHI) begin
      hi_d = A;
    end else if (start && op == MDU_MTLO) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      commit_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      commit_q  <= commit_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus pushes the expected HI/LO and due cycle, a negedge monitor checks.
module tb_mdu_hilo;

  localparam int NMUL = 5;
  localparam int NDIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        hilo_sel = 1'b0;
  logic        busy, md_pend;
  logic [31:0] HI, LO, RD;

  mdu_hilo #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .md_pend  (md_pend),
    .HI       (HI),
    .LO       (LO),
    .RD       (RD)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          chk_run;
    int          run;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  int          ready_cyc = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  int          busy_run = 0;
  int          last_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops an expectation when its due cycle arrives; otherwise HI/LO must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_run++;
      else begin
        if (busy_run != 0) last_run = busy_run;
        busy_run = 0;
      end
      if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        exp_t m;
        m = exp_q.pop_front();
        chk("missed_due", 64'(cyc), 64'(m.due));
      end
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn cycle=%0d HI=0x%08h LO=0x%08h exp HI=0x%08h LO=0x%08h busy_run=%0d",
                 cyc, HI, LO, e.hi, e.lo, last_run);
        chk("hi", 64'(HI), 64'(e.hi));
        chk("lo", 64'(LO), 64'(e.lo));
        chk("busy_done", 64'(busy), 64'(0));
        if (e.chk_run) chk("busy_len", 64'(last_run), 64'(e.run));
        last_run = 0;
        last_hi  = e.hi;
        last_lo  = e.lo;
      end else begin
        chk("hilo_stable", {HI, LO}, {last_hi, last_lo});
      end
      chk("rd", 64'(RD), 64'(hilo_sel ? last_hi : last_lo));
    end
  end

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          t;
    int          sa, sb;
    longint      ps;
    logic [63:0] pu, ua, ub;
    bit          is_md;
    while (cyc < ready_cyc) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; op = o; A = a; B = b;
    hilo_sel = 1'($urandom_range(0, 1));
    t = cyc + 1;
    sa = int'(a); sb = int'(b);
    is_md = (o >= 3'd1 && o <= 3'd4);
    case (o)
      3'd1: begin ps = longint'(sa) * longint'(sb); model_hi = ps[63:32]; model_lo = ps[31:0]; end
      3'd2: begin ua = {32'd0, a}; ub = {32'd0, b}; pu = ua * ub; model_hi = pu[63:32]; model_lo = pu[31:0]; end
      3'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          model_lo = 32'h8000_0000; model_hi = 32'h0;
        end else begin
          model_lo = 32'(sa / sb); model_hi = 32'(sa % sb);
        end
      end
      3'd4: if (b != 0) begin model_lo = a / b; model_hi = a % b; end
      3'd5: model_hi = a;
      3'd6: model_lo = a;
      default: ;
    endcase
    e.hi = model_hi; e.lo = model_lo;
    if (is_md) begin
      e.run = (o <= 3'd2) ? NMUL : NDIV;
      e.due = t + e.run; e.chk_run = 1'b1;
      exp_q.push_back(e);
      ready_cyc = e.due;
    end else if (o == 3'd5 || o == 3'd6) begin
      e.run = 0; e.due = t; e.chk_run = 1'b0;
      exp_q.push_back(e);
      ready_cyc = t;
    end else begin
      ready_cyc = t;
    end
    #1;
    chk("md_pend", 64'(md_pend), 64'(is_md));
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0;
  endtask

  // Drives one start regardless of the unit's state and records no expectation.
  task automatic issue_raw(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op = o; A = a;
    #1;
    chk("md_pend_busy", 64'(md_pend), 64'(0));
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t r;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    r.due = cyc; r.chk_run = 1'b0; r.run = 0; r.hi = '0; r.lo = '0;
    exp_q.push_back(r);
    reset = 1'b0;
    ready_cyc = cyc;

    issue(3'd5, 32'h0000_1234, 32'h0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    issue(3'd4, 32'd7, 32'd2);
    issue(3'd5, 32'h0000_00AA, 32'h0);
    issue(3'd6, 32'h0000_00BB, 32'h0);
    issue(3'd3, 32'h0000_1000, 32'h0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);

    // MTLO while a multiply is running must be dropped.
    issue(3'd1, 32'h0001_0003, 32'hFFFF_0007);
    @(posedge clk); #1;
    issue_raw(3'd6, 32'h0000_0055);
    issue_raw(3'd5, 32'h0000_0066);
    // Back-to-back: the second issue is driven in the cycle busy falls.
    issue(3'd1, 32'd1000, 32'hFFFF_FF00);
    issue(3'd2, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(3'd0, 32'h1, 32'h1);
    issue(3'd7, 32'h2, 32'h2);

    // Reset in the fourth busy cycle of a divide aborts it with no later commit.
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    exp_q.delete();
    model_hi = '0; model_lo = '0;
    r.due = cyc + 1; r.chk_run = 1'b0; r.run = 0; r.hi = '0; r.lo = '0;
    exp_q.push_back(r);
    ready_cyc = cyc + 1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (NDIV + 4) begin @(posedge clk); #1; end
    chk("no_commit_after_reset", {HI, LO}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = ($urandom_range(0, 6) == 0) ? 32'd0 : rnd_operand();
      issue(o, a, b);
    end

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
